// File: rtl/afpm_pkg.sv
// Shared definitions for the approximate FP16 multiplier: operand and byte-lane widths,
// the byte-serial frame state, and the default idle-timeout length for the operand loader.
// Ports: none (package only).
package afpm_pkg;

  localparam int BYTE_W = 8;
  localparam int OP_W   = 2 * BYTE_W;

  // Idle cycles spent in HIGH before a half-received frame is abandoned.
  // Only used when AFPM_LOADER_TIMEOUT_EN is defined.
  localparam int TIMEOUT_CYC = 8;

  typedef enum logic {
    FRAME_LOW  = 1'b0,
    FRAME_HIGH = 1'b1
  } frame_state_e;

endpackage

// File: rtl/afpm_byte_assembler.sv
// One byte lane of the operand loader: stages the low byte and forms {high, low}.
// Ports: clk/rst_n (async active-low), capture_i loads byte_i into the low stage,
//        word_o is the combinational {byte_i, staged low} presented on the high beat.
module afpm_byte_assembler
  import afpm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [OP_W-1:0]   word_o
);

  logic [BYTE_W-1:0] low_q;
  logic [BYTE_W-1:0] low_d;

  always_comb begin
    low_d = low_q;
    if (capture_i) begin
      low_d = byte_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_q <= '0;
    end else begin
      low_q <= low_d;
    end
  end

  // Only meaningful on the high beat; the top decides whether to use it.
  assign word_o = {byte_i, low_q};

endmodule

// File: rtl/afpm_operand_loader.sv
// Byte-serial operand front end: assembles A/B operands from two byte lanes (low byte
// first) and holds the pair in a one-entry output register with a valid/ready handshake.
// Ports: clk, rst_n (async active-low), ena (global gate), in_valid/byte_a/byte_b (beat),
//        op_a/op_b/op_valid/op_ready (core handshake), frame_phase (FSM state), overrun (sticky).
// Optional: define AFPM_LOADER_TIMEOUT_EN to abandon a half frame after TIMEOUT_CYC idle cycles.
module afpm_operand_loader
  import afpm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] byte_a,
  input  logic [BYTE_W-1:0] byte_b,
  output logic [OP_W-1:0]   op_a,
  output logic [OP_W-1:0]   op_b,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              frame_phase,
  output logic              overrun
);

  frame_state_e    state_q, state_d;
  logic [OP_W-1:0] op_a_q, op_a_d;
  logic [OP_W-1:0] op_b_q, op_b_d;
  logic            op_valid_q, op_valid_d;
  logic            overrun_q, overrun_d;

  logic            beat;
  logic            capture_low;
  logic            pair_done;
  logic            can_load;
  logic [OP_W-1:0] word_a;
  logic [OP_W-1:0] word_b;

  assign beat        = ena & in_valid;
  assign capture_low = beat & (state_q == FRAME_LOW);
  assign pair_done   = beat & (state_q == FRAME_HIGH);
  // The holding register frees up in the same cycle the core takes the current pair.
  assign can_load    = ~op_valid_q | op_ready;

  afpm_byte_assembler u_lane_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture_i (capture_low),
    .byte_i    (byte_a),
    .word_o    (word_a)
  );

  afpm_byte_assembler u_lane_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture_i (capture_low),
    .byte_i    (byte_b),
    .word_o    (word_b)
  );

`ifdef AFPM_LOADER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             timeout_hit;

  // Fires on the idle cycle that brings the count up to TIMEOUT_CYC.
  assign timeout_hit = (state_q == FRAME_HIGH) & ena & ~in_valid &
                       (idle_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (state_q != FRAME_HIGH || beat || timeout_hit) begin
      idle_cnt_d = '0;
    end else if (ena) begin
      idle_cnt_d = idle_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic timeout_hit;
  assign timeout_hit = 1'b0;
`endif

  // Frame FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FRAME_LOW: begin
        if (beat) state_d = FRAME_HIGH;
      end
      FRAME_HIGH: begin
        // Staged low bytes are left in place on timeout; the next low beat overwrites them.
        if (beat || timeout_hit) state_d = FRAME_LOW;
      end
      default: state_d = FRAME_LOW;
    endcase
  end

  // Output holding register and handshake.
  always_comb begin
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = op_valid_q;
    overrun_d  = overrun_q;

    if (op_valid_q && op_ready) begin
      op_valid_d = 1'b0;
    end

    if (pair_done) begin
      if (can_load) begin
        op_a_d     = word_a;
        op_b_d     = word_b;
        op_valid_d = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FRAME_LOW;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_valid    = op_valid_q;
  assign frame_phase = state_q;
  assign overrun     = overrun_q;

endmodule
